// File: rtl/fir_kernel_sequencer.sv
// fir_kernel_sequencer
//   Drives one HLS FIR kernel (ap_ctrl_hs) from a valid/ready sample stream.
//   Each accepted sample is one kernel call. The call's result is returned on
//   a valid/ready result stream. The block also records call latency and the
//   number of completed transactions.
//
//   Optional build macro: FIR_SEQ_TIMEOUT_EN
//     Adds a watchdog on START+WAIT. When TIMEOUT_CYC cycles pass without
//     ap_done, the block sets the sticky timeout_err, drops the call and
//     returns to IDLE. When the macro is undefined, timeout_err is tied 0 and
//     err_clr is ignored.
//
//   Ports
//     clock, reset_n              clock, asynchronous active-low reset
//     enable                      gates acceptance of new samples only
//     s_valid/s_ready/s_data      sample stream in
//     m_valid/m_ready/m_data      filter result stream out
//     fir_ap_start/ready/done     kernel block-level handshake
//     fir_x, fir_y                kernel argument / return value
//     busy                        not idle
//     txn_count                   results handed off (wraps)
//     last_latency, max_latency   START..ap_done cycles, inclusive (saturating)
//     err_clr, timeout_err        watchdog error clear / sticky flag
module fir_kernel_sequencer #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 32,
    parameter int LAT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              fir_ap_start,
    input  logic              fir_ap_ready,
    input  logic              fir_ap_done,
    output logic [DATA_W-1:0] fir_x,
    input  logic [DATA_W-1:0] fir_y,
    output logic              busy,
    output logic [CNT_W-1:0]  txn_count,
    output logic [LAT_W-1:0]  last_latency,
    output logic [LAT_W-1:0]  max_latency,
    input  logic              err_clr,
    output logic              timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

    state_t           state, state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic             accept;
    logic             capture;
    logic             wd_fire;

    // ap_done is honoured only while a call is outstanding.
    assign accept  = (state == S_IDLE) && enable && s_valid;
    assign capture = ((state == S_START) || (state == S_WAIT)) && fir_ap_done;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: begin
                if (fir_ap_done)       state_nxt = S_OUT;
                else if (wd_fire)      state_nxt = S_IDLE;
                else if (fir_ap_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (fir_ap_done)  state_nxt = S_OUT;
                else if (wd_fire) state_nxt = S_IDLE;
            end
            S_OUT:   if (m_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode from the state alone. An asynchronous reset therefore
    // drops ap_start and m_valid immediately.
    always_comb begin
        s_ready      = (state == S_IDLE) && enable;
        fir_ap_start = (state == S_START);
        m_valid      = (state == S_OUT);
        busy         = (state != S_IDLE);
    end

    // Datapath and statistics
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fir_x        <= '0;
            m_data       <= '0;
            lat_cnt      <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            txn_count    <= '0;
        end else begin
            if (accept) begin
                fir_x   <= s_data;
                lat_cnt <= LAT_W'(1);
            end else if (((state == S_START) || (state == S_WAIT)) && (lat_cnt != '1)) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
            if (capture) begin
                m_data       <= fir_y;
                last_latency <= lat_cnt;
                if (lat_cnt > max_latency) max_latency <= lat_cnt;
            end
            if ((state == S_OUT) && m_ready) txn_count <= txn_count + CNT_W'(1);
        end
    end

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;

    // wd_cnt is 1 in the first START cycle. The watchdog fires in the
    // TIMEOUT_CYC-th outstanding cycle.
    assign wd_fire = ((state == S_START) || (state == S_WAIT)) && !fir_ap_done &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept)                                         wd_cnt <= WD_W'(1);
            else if ((state == S_START) || (state == S_WAIT))   wd_cnt <= wd_cnt + WD_W'(1);
            // A new timeout has priority over a clear in the same cycle.
            if (wd_fire)      timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end
`else
    logic unused_wd;

    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_wd   = err_clr ^ (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_fir_kernel_sequencer.sv
// Directed bench for fir_kernel_sequencer. The bench acts as the kernel,
// the sample source and the result sink. Inputs are driven and outputs are
// sampled 1 time unit after the rising edge.
module tb_fir_kernel_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable, s_valid, s_ready, m_valid, m_ready;
    logic [31:0] s_data, m_data, fir_x, fir_y;
    logic        fir_ap_start, fir_ap_ready, fir_ap_done, busy;
    logic [31:0] txn_count;
    logic [15:0] last_latency, max_latency;
    logic        err_clr, timeout_err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    fir_kernel_sequencer #(.DATA_W(32), .CNT_W(32), .LAT_W(16), .TIMEOUT_CYC(16)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .fir_ap_start(fir_ap_start), .fir_ap_ready(fir_ap_ready), .fir_ap_done(fir_ap_done),
        .fir_x(fir_x), .fir_y(fir_y), .busy(busy), .txn_count(txn_count),
        .last_latency(last_latency), .max_latency(max_latency),
        .err_clr(err_clr), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one sample for one cycle. On return the DUT is in START cycle 1.
    task automatic send(input logic [31:0] x);
        s_valid = 1'b1;
        s_data  = x;
        tick();
        s_valid = 1'b0;
    endtask

    // Kernel model, called in START cycle 1. It asserts ap_ready in cycle 1
    // and ap_done in cycle lat. lat==1 gives ready and done together.
    task automatic kern(input int lat, input logic [31:0] y);
        if (lat == 1) begin
            fir_ap_ready = 1'b1; fir_ap_done = 1'b1; fir_y = y;
            tick();
            fir_ap_ready = 1'b0; fir_ap_done = 1'b0;
        end else begin
            fir_ap_ready = 1'b1;
            tick();
            fir_ap_ready = 1'b0;
            repeat (lat - 2) tick();
            fir_ap_done = 1'b1; fir_y = y;
            tick();
            fir_ap_done = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        fir_ap_ready = 1'b0; fir_ap_done = 1'b0; fir_y = '0; err_clr = 1'b0;
        #12;
        // Reset state
        chk("rst_start", fir_ap_start, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn", txn_count, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_firx", fir_x, 0);
        chk("rst_tmo", timeout_err, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick();
        chk("idle_sready_dis", s_ready, 0);
        enable = 1'b1;
        #1;
        chk("idle_sready_en", s_ready, 1);

        // Single sample: ap_ready in cycle 1 and ap_done in cycle 4
        send(32'd5);
        chk("s1_start", fir_ap_start, 1);
        chk("s1_firx", fir_x, 5);
        fir_ap_ready = 1'b1;
        tick();
        fir_ap_ready = 1'b0;
        chk("s1_start_one_cycle", fir_ap_start, 0);
        chk("s1_busy", busy, 1);
        repeat (2) tick();
        fir_ap_done = 1'b1; fir_y = 32'h50;
        tick();
        fir_ap_done = 1'b0;
        chk("s1_mvalid", m_valid, 1);
        chk("s1_mdata", m_data, 32'h50);
        chk("s1_lastlat", last_latency, 4);
        chk("s1_maxlat", max_latency, 4);
        chk("s1_sready_out", s_ready, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("s1_txn", txn_count, 1);
        chk("s1_idle", busy, 0);

        // Ready and done in the same cycle: START goes straight to OUT
        send(32'd2);
        kern(1, 32'd7);
        chk("sc_mvalid", m_valid, 1);
        chk("sc_mdata", m_data, 7);
        chk("sc_lastlat", last_latency, 1);
        chk("sc_maxlat", max_latency, 4);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("sc_txn", txn_count, 2);

        // Output backpressure for 10 cycles
        send(32'd9);
        kern(2, 32'h99);
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_mvalid", m_valid, 1);
            chk("bp_mdata", m_data, 32'h99);
            chk("bp_sready", s_ready, 0);
            chk("bp_txn", txn_count, 2);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("bp_txn_release", txn_count, 3);
        chk("bp_idle", m_valid, 0);

        // Stream of 8 samples with latencies 2..9; results are checked in order
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h10 + i);
            chk("st_firx", fir_x, 32'h10 + i);
            kern(i + 2, 32'hA500 + i);
            chk("st_mdata", m_data, 32'hA500 + i);
            chk("st_lastlat", last_latency, i + 2);
            tick();
        end
        m_ready = 1'b0;
        chk("st_txn", txn_count, 11);
        chk("st_maxlat", max_latency, 9);

        // enable dropped mid-transaction: the call still completes
        send(32'h77);
        enable = 1'b0;
        kern(3, 32'h55);
        chk("en_mdata", m_data, 32'h55);
        chk("en_mvalid", m_valid, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("en_txn", txn_count, 12);
        s_valid = 1'b1; s_data = 32'h1234;
        tick(); tick();
        chk("en_sready", s_ready, 0);
        chk("en_busy", busy, 0);
        s_valid = 1'b0;

        // ap_done in IDLE is ignored
        fir_ap_done = 1'b1; fir_y = 32'hDEAD;
        tick();
        fir_ap_done = 1'b0;
        chk("viol_mvalid", m_valid, 0);
        chk("viol_mdata", m_data, 32'h55);
        chk("viol_busy", busy, 0);

        // Reset asserted in the middle of WAIT
        enable = 1'b1;
        send(32'd1);
        fir_ap_ready = 1'b1;
        tick();
        fir_ap_ready = 1'b0;
        chk("rw_busy_before", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_start", fir_ap_start, 0);
        chk("rw_mvalid", m_valid, 0);
        chk("rw_busy", busy, 0);
        chk("rw_txn", txn_count, 0);
        chk("rw_maxlat", max_latency, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick();
        send(32'd3);
        kern(2, 32'h42);
        chk("rw_post_mdata", m_data, 32'h42);
        chk("rw_post_lat", last_latency, 2);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("rw_post_txn", txn_count, 1);

`ifdef FIR_SEQ_TIMEOUT_EN
        // The kernel never returns ap_done. The watchdog fires in cycle 16.
        send(32'd4);
        fir_ap_ready = 1'b1;
        tick();
        fir_ap_ready = 1'b0;
        repeat (14) tick();
        chk("to_pre_err", timeout_err, 0);
        chk("to_pre_busy", busy, 1);
        tick();
        chk("to_err", timeout_err, 1);
        chk("to_idle", busy, 0);
        chk("to_mvalid", m_valid, 0);
        chk("to_txn", txn_count, 1);
        tick();
        chk("to_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", timeout_err, 0);
`else
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("no_wd_err", timeout_err, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Bound on the total run time
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/fir_kernel_sequencer.md
Name: fir_kernel_sequencer

Overview:
- Controller that drives one HLS-generated FIR kernel (ap_ctrl_hs block-level protocol) from a valid/ready sample stream.
- Serializes samples into the kernel (one call per sample, since the kernel's shift register is stateful) and returns each filter output on a valid/ready result stream.
- Keeps per-transaction latency and transaction-count statistics for the testbench and status readout.
- Sits between the sample source and the FIR kernel instance in the FIR subsystem top.

Parameters:
- DATA_W, 32, width of input sample x and kernel output y
- CNT_W, 32, width of completed-transaction counter
- LAT_W, 16, width of latency registers (saturating)
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- clock  in  1  single clock domain, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  permits acceptance of new samples
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid && s_ready
- s_data  in  DATA_W  input sample
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_data  out  DATA_W  filter output
- fir_ap_start  out  1  kernel start
- fir_ap_ready  in  1  kernel has consumed its inputs
- fir_ap_done  in  1  kernel call complete, fir_y valid this cycle
- fir_x  out  DATA_W  kernel input argument
- fir_y  in  DATA_W  kernel output argument
- busy  out  1  state != IDLE
- txn_count  out  CNT_W  completed transactions (result handed off)
- last_latency  out  LAT_W  cycles from first START cycle to the ap_done cycle, inclusive
- max_latency  out  LAT_W  largest last_latency since reset
- err_clr  in  1  clears timeout_err (optional feature)
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (reset_n).
- Reset values: state IDLE; all outputs 0; fir_x 0; m_data 0; counters 0.
- Reset mid-operation: fir_ap_start drops asynchronously and the in-flight sample is discarded.
- IDLE:
  - s_ready = enable.
  - On s_valid && s_ready: register s_data into fir_x, set latency counter to 1, go to START.
- START:
  - fir_ap_start = 1; fir_x held stable.
  - Latency counter increments each cycle.
  - On fir_ap_ready, fir_ap_start deasserts next cycle.
  - If fir_ap_done is asserted in the same cycle, capture fir_y into m_data and go to OUT; otherwise go to WAIT.
- WAIT:
  - fir_ap_start = 0; latency counter increments.
  - On fir_ap_done, capture fir_y into m_data and go to OUT.
- Latency update: on the ap_done capture cycle, last_latency = counter value, and max_latency = max(max_latency, that value). The counter saturates at all-ones and never wraps.
- OUT:
  - m_valid = 1; m_data stable while m_valid && !m_ready.
  - On m_ready, txn_count increments (wraps modulo 2^CNT_W) and state goes to IDLE.
  - No back-to-back bypass: at least one IDLE cycle between transactions, so s_ready is 0 in the OUT cycle.
- Kernel-protocol violations:
  - fir_ap_done in IDLE or OUT is ignored.
  - fir_ap_ready outside START is ignored.
- enable deasserted mid-transaction: the current transaction completes; only new acceptance is blocked.
- Throughput: best case one sample per (kernel latency + 2) cycles.

Optional Feature:
- Macro: FIR_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in START+WAIT.
  - On reaching TIMEOUT_CYC without fir_ap_done: set timeout_err (sticky), drop fir_ap_start, return to IDLE with no result emitted, and leave txn_count unchanged.
  - err_clr = 1 clears timeout_err next cycle. If a new timeout fires in the same cycle as err_clr, set wins.
- Undefined: no watchdog logic; timeout_err tied 0; err_clr ignored; a hung kernel stalls the sequencer indefinitely.

Test Plan:
- Single sample: s_data=5; kernel model ap_ready at start cycle 1, ap_done 3 cycles later with y=0x50 -> m_data=0x50, last_latency=4, max_latency=4, txn_count=1, fir_ap_start high exactly 1 cycle.
- Same-cycle ready+done: kernel asserts ap_ready and ap_done together on the first START cycle, y=7 -> OUT directly, last_latency=1, no WAIT state visited.
- Output backpressure: m_ready held 0 for 10 cycles -> m_valid stays 1, m_data constant, s_ready=0 throughout, txn_count increments only on the release cycle.
- Stream of 8 samples with kernel latencies 2..9 -> txn_count=8, max_latency=9, results in input order; enable dropped mid-run -> in-flight transaction finishes and s_ready stays 0 afterwards.
- Reset mid-WAIT: assert reset_n=0 asynchronously -> fir_ap_start, m_valid, busy and counters are 0 immediately; after release a new sample completes normally.
- With FIR_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16: kernel never returns ap_done -> timeout_err=1 at cycle 16, state IDLE, txn_count unchanged; err_clr pulse -> timeout_err=0.
